// File: rtl/program_memory_pkg.sv
// Shared CPU definitions: program-memory FSM states, instruction opcode
// fields and the fallback word returned for reads that cannot be served.
package program_memory_pkg;

    // Program-memory controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } pm_state_t;

    // Opcode field of a 28-bit instruction word.
    localparam int OPCODE_MSB   = 27;
    localparam int OPCODE_LSB   = 20;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_WIDTH-1:0] OPC_NOP  = 8'h00;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JMP  = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = 8'hFF;

    // Seed of the default word: zero opcode byte over a 24-bit 0xAA payload.
    // Modules cast it to their own data width, which zero-pads or truncates.
    localparam logic [31:0] DEFAULT_WORD_SEED = {8'd0, 24'hAA};

    // Number of bytes needed to hold one word of the given width.
    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/program_memory_if.sv
// Load and read bus of the program memory.
// Handshake: a load byte transfers on a rising edge where iLoadValid and
// oLoadReady are both 1; iLoadData must be stable while iLoadValid is high,
// and neither side may make iLoadValid wait on anything but oLoadReady.
interface program_memory_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 28
);
    logic                  iLoadStart;
    logic [7:0]            iLoadData;
    logic                  iLoadValid;
    logic                  oLoadReady;
    logic                  oLoadDone;
    logic                  iReadEnable;
    logic [ADDR_WIDTH-1:0] iAddress;
    logic [DATA_WIDTH-1:0] oInstruction;
    logic                  oValid;
    logic                  oBusy;

    modport master (
        output iLoadStart, iLoadData, iLoadValid, iReadEnable, iAddress,
        input  oLoadReady, oLoadDone, oInstruction, oValid, oBusy
    );

    modport slave (
        input  iLoadStart, iLoadData, iLoadValid, iReadEnable, iAddress,
        output oLoadReady, oLoadDone, oInstruction, oValid, oBusy
    );
endinterface

// File: rtl/byte_packer.sv
// Assembles incoming bytes into words, most significant byte first.
// The completed word is presented combinationally together with the last
// byte, so the caller can write it on the same edge that accepts that byte.
module byte_packer
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic                  iClear,
    input  logic [7:0]            iByte,
    input  logic                  iAccept,
    output logic [DATA_WIDTH-1:0] oWord,
    output logic                  oWordValid
);
    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_last_byte;

    // Shifting in the new byte pushes earlier bytes upward; anything beyond
    // DATA_WIDTH falls off, which discards the unused top bits of byte 0.
    assign w_last_byte = (r_count == CW'(BPW - 1));
    assign oWord       = DATA_WIDTH'({r_word, iByte});
    assign oWordValid  = iAccept && w_last_byte;

    // Byte counter and partial word; a clear drops any half-built word.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (iClear) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (iAccept) begin
            if (w_last_byte) begin
                r_count <= '0;
                r_word  <= '0;
            end else begin
                r_count <= r_count + CW'(1);
                r_word  <= oWord;
            end
        end
    end
endmodule

// File: rtl/program_memory.sv
// Byte-loadable instruction memory with a single-cycle read port.
// A load streams DEPTH words into the RAM; reads are served only once the
// whole program is present, otherwise DEFAULT_WORD is returned.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(DEFAULT_WORD_SEED)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    program_memory_if.slave   bus,
    output pm_state_t         oDbgState
);
    localparam int                  MW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    pm_state_t             r_state;
    pm_state_t             w_next_state;
    logic                  w_load_ready;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_valid;
    logic                  w_read_hit;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_done;
    logic                  r_valid;
    logic                  r_use_default;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Reset asserts immediately and releases two edges after Reset_n rises.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // A start request always wins over a byte offered in the same cycle.
    assign w_accept = bus.iLoadValid && w_load_ready && !bus.iLoadStart;
    assign w_last   = (r_waddr == LAST_ADDR);

    byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .iClock     (Clock),
        .iReset_n   (w_rst_n),
        .iClear     (bus.iLoadStart),
        .iByte      (bus.iLoadData),
        .iAccept    (w_accept),
        .oWord      (w_word),
        .oWordValid (w_word_valid)
    );

    // State register.
    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state and load-side flags: start restarts from anywhere, the
    // final word write finishes the load.
    always_comb begin
        w_next_state = r_state;
        w_load_ready = 1'b0;
        if (r_state == ST_LOAD) w_load_ready = 1'b1;
        if (bus.iLoadStart) begin
            w_next_state = ST_LOAD;
        end else if ((r_state == ST_LOAD) && w_word_valid && w_last) begin
            w_next_state = ST_READY;
        end
    end

    // Word address advances after each write and stops at DEPTH-1.
    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n)                    r_waddr <= '0;
        else if (bus.iLoadStart)         r_waddr <= '0;
        else if (w_word_valid && !w_last) r_waddr <= r_waddr + ADDR_WIDTH'(1);
    end

    // One-cycle done pulse following the write of the last word.
    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) r_done <= 1'b0;
        else          r_done <= w_word_valid && w_last && !bus.iLoadStart;
    end

    // RAM write port; contents survive reset and are only reachable in READY.
    always_ff @(posedge Clock) begin
        if (w_word_valid) r_mem[r_waddr[MW-1:0]] <= w_word;
    end

    // Reads during a load (including one colliding with a write) miss.
    assign w_read_hit = (r_state == ST_READY) && ({1'b0, bus.iAddress} < DEPTH_W);

    // Synchronous RAM read port, kept reset-free so it maps onto block RAM.
    always_ff @(posedge Clock) begin
        if (bus.iReadEnable && w_read_hit) r_rdata <= r_mem[bus.iAddress[MW-1:0]];
    end

    // Read status: valid strobe and whether the output shows DEFAULT_WORD.
    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_valid       <= 1'b0;
            r_use_default <= 1'b1;
        end else begin
            r_valid <= bus.iReadEnable;
            if (bus.iReadEnable) r_use_default <= !w_read_hit;
        end
    end

    assign bus.oLoadReady   = w_load_ready;
    assign bus.oBusy        = w_load_ready;
    assign bus.oLoadDone    = r_done;
    assign bus.oValid       = r_valid;
    assign bus.oInstruction = r_use_default ? DEFAULT_WORD : r_rdata;
    assign oDbgState        = r_state;
endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory with DEPTH=4 and 28-bit words.
module tb_program_memory;
    import program_memory_pkg::*;

    localparam int DW    = 28;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam logic [31:0] DEF = 32'h0000_00AA;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    pm_state_t dbg_state;

    program_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pm_if ();

    program_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .Clock     (clk),
        .Reset_n   (rst_n),
        .bus       (pm_if),
        .oDbgState (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_done = 0;
    logic [31:0] exp_q [$];
    logic [31:0] img  [3][4];   // byte images fed to the DUT, MSB first
    logic [31:0] want [3][4];   // hand-computed 28-bit words they produce

    // Done-pulse monitor
    always @(negedge clk) begin
        if (pm_if.oLoadDone === 1'b1) n_done++;
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            pm_if.iLoadValid = 1'b0;
            pm_if.iLoadData  = 8'hEE;
            tick();
        end
        pm_if.iLoadValid = 1'b1;
        pm_if.iLoadData  = b;
        tick();
        pm_if.iLoadValid = 1'b0;
    endtask

    task automatic start_load(input bit with_byte);
        pm_if.iLoadStart = 1'b1;
        pm_if.iLoadValid = with_byte;
        pm_if.iLoadData  = 8'h55;
        tick();
        pm_if.iLoadStart = 1'b0;
        pm_if.iLoadValid = 1'b0;
        check("busy_after_start", {31'd0, pm_if.oBusy}, 32'd1);
        check("ready_after_start", {31'd0, pm_if.oLoadReady}, 32'd1);
    endtask

    task automatic load_set(input int s, input bit gap);
        int d0;
        logic [31:0] v;
        d0 = n_done;
        for (int w = 0; w < 4; w++) begin
            v = img[s][w];
            for (int b = 3; b >= 0; b--) send_byte(v[b*8 +: 8], gap);
        end
        check("done_pulse", {31'd0, pm_if.oLoadDone}, 32'd1);
        check("busy_after_load", {31'd0, pm_if.oBusy}, 32'd0);
        check("state_ready", 32'(dbg_state), 32'(ST_READY));
        tick();
        check("done_single", {31'd0, pm_if.oLoadDone}, 32'd0);
        check("done_count", n_done - d0, 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
        pm_if.iReadEnable = 1'b1;
        pm_if.iAddress    = addr;
        exp_q.push_back(exp);
        tick();
        pm_if.iReadEnable = 1'b0;
        check({tag, "_valid"}, {31'd0, pm_if.oValid}, 32'd1);
        check(tag, 32'(pm_if.oInstruction), exp_q.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, 32'(pm_if.oInstruction), DEF);
        check({tag, "_valid"}, {31'd0, pm_if.oValid}, 32'd0);
        check({tag, "_busy"},  {31'd0, pm_if.oBusy}, 32'd0);
        check({tag, "_ready"}, {31'd0, pm_if.oLoadReady}, 32'd0);
        check({tag, "_done"},  {31'd0, pm_if.oLoadDone}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int d0;
        logic [31:0] v;

        img[0]  = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        want[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        img[1]  = '{32'hFF23_4567, 32'h089A_BCDE, 32'h0000_0AA5, 32'h07FF_FFFF};
        want[1] = '{32'h0F23_4567, 32'h089A_BCDE, 32'h0000_0AA5, 32'h07FF_FFFF};
        img[2]  = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0012, 32'h0000_0013};
        want[2] = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0012, 32'h0000_0013};

        pm_if.iLoadStart  = 1'b0;
        pm_if.iLoadData   = 8'h00;
        pm_if.iLoadValid  = 1'b0;
        pm_if.iReadEnable = 1'b0;
        pm_if.iAddress    = '0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Read before any load returns the default word
        do_read(16'd0, DEF, "idle_rd0");
        check("idle_busy", {31'd0, pm_if.oBusy}, 32'd0);
        tick();
        check("hold_valid", {31'd0, pm_if.oValid}, 32'd0);
        check("hold_instr", 32'(pm_if.oInstruction), DEF);

        // Plain load of 1..4
        start_load(1'b0);
        load_set(0, 1'b0);
        for (int a = 0; a < 4; a++) do_read(AW'(a), want[0][a], "rd_set0");

        // Address boundaries
        do_read(16'd4, DEF, "rd_depth");
        do_read(16'd3, want[0][3], "rd_last");
        do_read(16'hFFFF, DEF, "rd_max");
        tick();
        check("hold_after_default", 32'(pm_if.oInstruction), DEF);

        // Load with valid toggling, including truncated top bits
        start_load(1'b0);
        load_set(1, 1'b1);
        for (int a = 0; a < 4; a++) do_read(AW'(a), want[1][a], "rd_set1");
        tick();
        check("hold_set1", 32'(pm_if.oInstruction), want[1][3]);

        // Abort after 6 bytes, with a read colliding with a word write
        d0 = n_done;
        start_load(1'b0);
        for (int i = 0; i < 6; i++) begin
            v = img[0][i / 4];
            if (i == 3) begin
                pm_if.iReadEnable = 1'b1;
                pm_if.iAddress    = 16'd0;
            end
            send_byte(v[(3 - (i % 4))*8 +: 8], 1'b0);
            if (i == 3) begin
                pm_if.iReadEnable = 1'b0;
                check("rd_during_load_valid", {31'd0, pm_if.oValid}, 32'd1);
                check("rd_during_load", 32'(pm_if.oInstruction), DEF);
            end
        end
        start_load(1'b1);   // start and a byte together: the byte is dropped
        load_set(2, 1'b0);
        for (int a = 0; a < 4; a++) do_read(AW'(a), want[2][a], "rd_set2");
        check("reload_done_once", n_done - d0, 32'd1);

        // Reset in the middle of byte 9
        do_read(16'd3, want[2][3], "rd_pre_reset");
        start_load(1'b0);
        for (int i = 0; i < 8; i++) begin
            v = img[0][i / 4];
            send_byte(v[(3 - (i % 4))*8 +: 8], 1'b0);
        end
        pm_if.iLoadValid = 1'b1;
        pm_if.iLoadData  = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        pm_if.iLoadValid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        do_read(16'd0, DEF, "post_rst_rd0");
        do_read(16'd3, DEF, "post_rst_rd3");
        check("post_rst_busy", {31'd0, pm_if.oBusy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The module SHALL take parameters:
- DATA_WIDTH, default 28: instruction word width.
- ADDR_WIDTH, default 16: address width.
- DEPTH, default 64: number of stored words, where DEPTH <= 2^ADDR_WIDTH.
- DEFAULT_WORD, default {8'd0, 24'hAA} padded to DATA_WIDTH: word returned for invalid reads.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The module SHALL have these ports:
- Clock, input, 1: rising-edge clock.
- Reset_n, input, 1: asynchronous active-low reset.
- iLoadStart, input, 1: single-cycle request to (re)start a program load.
- iLoadData, input, 8: load byte.
- iLoadValid, input, 1: iLoadData is valid.
- oLoadReady, output, 1: a load byte can be accepted.
- oLoadDone, output, 1: single-cycle pulse when the last word has been written.
- iReadEnable, input, 1: read request.
- iAddress, input, ADDR_WIDTH: read address.
- oInstruction, output, DATA_WIDTH: read data.
- oValid, output, 1: oInstruction updated this cycle.
- oBusy, output, 1: a load is in progress.

Function
REQ-004 The state machine SHALL have the states IDLE, LOAD and READY; reset enters IDLE.
REQ-005 iLoadStart SHALL move the machine from any state to LOAD and clear the word address and byte counters to 0.
REQ-006 In LOAD, oLoadReady=1 and oBusy=1; in all other states both SHALL be 0.
REQ-007 A byte SHALL be accepted only in a cycle where iLoadValid=1 and oLoadReady=1.
REQ-008 BPW = ceil(DATA_WIDTH/8) bytes SHALL form one word, most significant byte first; bits above DATA_WIDTH SHALL be discarded.
REQ-009 When the BPW-th byte is accepted, the word SHALL be written at the current word address in the same clock edge, and the word address SHALL increment.
REQ-010 When the word at address DEPTH-1 is written, the module SHALL pulse oLoadDone for one cycle and go to READY.
REQ-011 If iLoadStart and iLoadValid are both asserted, iLoadStart SHALL win and the byte SHALL be dropped.
REQ-012 Read latency SHALL be 1: iReadEnable=1 at edge N gives oInstruction and oValid=1 after edge N+1; with iReadEnable=0, oValid=0 and oInstruction holds its value.
REQ-013 A read SHALL return DEFAULT_WORD when iAddress >= DEPTH, or when the state at the sampling edge is IDLE or LOAD.
REQ-014 Any other read SHALL return the stored word.
REQ-015 A read and a load write in the same cycle SHALL return DEFAULT_WORD, because the state is LOAD.
REQ-016 Address wrap-around SHALL NOT occur: the word address never exceeds DEPTH-1.

Reset
REQ-017 Asserting Reset_n=0 SHALL immediately force:
- state IDLE, with word and byte counters at 0;
- oInstruction=DEFAULT_WORD;
- oValid=0, oLoadReady=0, oLoadDone=0, oBusy=0.
REQ-018 The memory array SHALL NOT be reset; contents are unreachable until the next completed load.
REQ-019 A reset during LOAD SHALL abandon the load; a partly assembled word SHALL be lost.
REQ-020 Release of reset SHALL be synchronised in the standard manner so that the first active edge is clean.

Structure
REQ-021 The state encodings, the opcode field constants and the DEFAULT_WORD construction SHALL live in the shared definitions package used by the CPU.
REQ-022 Byte-to-word assembly SHALL be a sub-module named byte_packer, parametrised by DATA_WIDTH, with the outputs oWord and oWordValid.
REQ-023 Storage SHALL be an inferred synchronous-read RAM of DEPTH x DATA_WIDTH.

Verification
REQ-024 Reset, then a read at address 0 -> oInstruction=DEFAULT_WORD, oValid=1 after one cycle; oBusy=0.
REQ-025 DEPTH=4: iLoadStart, then 16 bytes 00 00 00 01 .. 00 00 00 04 -> oLoadDone pulses after byte 16; reads at 0..3 return 1..4 with latency 1.
REQ-026 Load with iLoadValid toggling every other cycle -> the same contents result, and no byte is accepted while iLoadValid=0.
REQ-027 After a load, read address DEPTH -> DEFAULT_WORD; read address DEPTH-1 -> the last loaded word.
REQ-028 iLoadStart after 6 of 16 bytes, then a full reload with 0x10..0x13 -> reads return 0x10..0x13; oLoadDone pulses exactly once.
REQ-029 Reset_n low during byte 9 of a load -> all outputs at reset values immediately; after release a read returns DEFAULT_WORD.
